reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the combined PLL lock flag and SDRAM init-done, and releases per-domain resets in order:
//  SDRAM -> NeoGeo core -> video/audio -> sys_ready. Runs on the 27 MHz reference clock.
//  Sits directly downstream of PLL instantiation; its outputs feed the per-domain reset synchronisers.
// PARAMETERS
//  LOCK_STABLE_CYCLES  2700   consecutive synced-lock cycles required before SDRAM reset release (100 us)
//  STAGE_GAP_CYCLES    27     cycles between core release and AV release, and between AV release and RUN
//  SDRAM_TIMEOUT       65535  max cycles in SDRAM_WAIT before a retry
//  CNT_W               16     shared counter width; must hold the largest of the three parameters above
// PORTS
//  clk_27m          in   1  27 MHz reference clock; the only clock
//  reset_n          in   1  synchronous, active-low reset
//  pll_locked       in   1  combined PLL lock; asynchronous, passed through a 2-flop synchroniser
//  sdram_init_done  in   1  SDRAM controller init complete; asynchronous, passed through a 2-flop synchroniser
//  clear_sticky     in   1  one-cycle pulse that clears lock_lost_sticky
//  rst_sdram_n      out  1  SDRAM domain reset, active low
//  rst_core_n       out  1  NeoGeo core reset, active low
//  rst_video_n      out  1  video/HDMI reset, active low
//  rst_audio_n      out  1  audio reset, active low
//  sys_ready        out  1  high only in RUN
//  lock_lost_sticky out  1  set when lock is lost while in RUN
//  sdram_retries    out  4  saturating count of SDRAM timeouts
//  seq_state        out  3  current state encoding, for debug
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=WAIT_LOCK; counter=0; sync flops=0; every output 0.
//  Reset applies the same way mid-sequence.
//  Outputs are registered and decode the current state: 0=WAIT_LOCK, 1=STABLE, 2=SDRAM_WAIT,
//  3=CORE_GAP, 4=AV_GAP, 5=RUN.
//   rst_sdram_n = 1 in states 2..5
//   rst_core_n  = 1 in states 3..5
//   rst_video_n = rst_audio_n = 1 in states 4..5
//  lock_s and done_s are the synchroniser outputs, 2 edges after the input changes.
//  Transitions, in priority order:
//   1) lock_s=0 in any state except WAIT_LOCK -> WAIT_LOCK, counter=0. If leaving RUN, set lock_lost_sticky.
//   2) WAIT_LOCK: lock_s=1 -> STABLE, counter=0.
//   3) STABLE: counter increments each cycle; at counter==LOCK_STABLE_CYCLES-1 -> SDRAM_WAIT, counter=0.
//   4) SDRAM_WAIT: done_s=1 -> CORE_GAP, counter=0.
//      Otherwise, at counter==SDRAM_TIMEOUT-1 -> STABLE, counter=0, sdram_retries+=1 (saturates at 15).
//      Going back to STABLE re-asserts rst_sdram_n for the full stabilise period.
//   5) CORE_GAP: at counter==STAGE_GAP_CYCLES-1 -> AV_GAP, counter=0.
//   6) AV_GAP:   at counter==STAGE_GAP_CYCLES-1 -> RUN.
//   7) RUN: held until lock loss. done_s deasserting in RUN is ignored.
//  Counter: unsigned CNT_W bits; cleared on every state change; never wraps within a state.
//  Sticky flag: clear_sticky=1 clears it; if set and clear happen in the same cycle, set wins.
//  Synchronous lock loss (event 1) drops every reset output on the same edge the state changes.
//  No combinational path from any input to any output.
// TESTING (bench parameters: LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, SDRAM_TIMEOUT=16)
//  1) Release reset, then raise pll_locked -> seq_state=1 at edge 3 and rst_sdram_n=1 at edge 11,
//     with the other resets still 0.
//  2) From SDRAM_WAIT, raise sdram_init_done -> rst_core_n=1 3 edges later; video/audio resets 4 edges after
//     that; sys_ready 4 edges after that.
//  3) Drop pll_locked for 1 cycle during STABLE -> WAIT_LOCK, stable count restarts from 0,
//     lock_lost_sticky stays 0.
//  4) In RUN, drop pll_locked -> 3 edges later all resets and sys_ready are 0 and lock_lost_sticky=1;
//     clear_sticky pulse -> 0.
//     Set and clear in the same cycle -> stays 1.
//  5) Hold sdram_init_done=0 -> 16 cycles after entering SDRAM_WAIT, rst_sdram_n=0 and sdram_retries=1;
//     after 20 timeouts sdram_retries=15.
//  6) reset_n=0 during AV_GAP -> at the next edge all outputs are 0 and seq_state=0;
//     after reset_n returns high with lock still held, the sequence restarts from STABLE.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment (PLL, SDRAM
// controller, per-domain reset synchronisers, debug).
interface reset_sequencer_if;
  // There is no valid/ready handshake on this bundle. pll_locked and
  // sdram_init_done are asynchronous levels. clear_sticky is a one-cycle pulse.
  // Every output is a registered level.
  logic       pll_locked;
  logic       sdram_init_done;
  logic       clear_sticky;
  logic       rst_sdram_n;
  logic       rst_core_n;
  logic       rst_video_n;
  logic       rst_audio_n;
  logic       sys_ready;
  logic       lock_lost_sticky;
  logic [3:0] sdram_retries;
  logic [2:0] seq_state;

  // The sequencer drives the resets and status outputs.
  modport master (
    input  pll_locked, sdram_init_done, clear_sticky,
    output rst_sdram_n, rst_core_n, rst_video_n, rst_audio_n,
    output sys_ready, lock_lost_sticky, sdram_retries, seq_state
  );

  // The environment drives the lock, init-done and clear inputs.
  modport slave (
    output pll_locked, sdram_init_done, clear_sticky,
    input  rst_sdram_n, rst_core_n, rst_video_n, rst_audio_n,
    input  sys_ready, lock_lost_sticky, sdram_retries, seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in order (SDRAM -> core -> video/audio -> ready)
// once the synchronised PLL lock has been stable and SDRAM init has completed.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 2700,
  parameter int STAGE_GAP_CYCLES   = 27,
  parameter int SDRAM_TIMEOUT      = 65535,
  parameter int CNT_W              = 16
) (
  input  logic              clk_27m,
  input  logic              reset_n,
  reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    SDRAM_WAIT = 3'd2,
    CORE_GAP   = 3'd3,
    AV_GAP     = 3'd4,
    RUN        = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SDRAM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_s1, lock_s, done_s1, done_s;
  logic             sticky_q, sticky_d;
  logic [3:0]       retries_q, retries_d;
  logic             rst_sdram_q, rst_core_q, rst_av_q, ready_q;

  always_ff @(posedge clk_27m) begin
    if (!reset_n) begin
      lock_s1     <= 1'b0;
      lock_s      <= 1'b0;
      done_s1     <= 1'b0;
      done_s      <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      retries_q   <= 4'd0;
      rst_sdram_q <= 1'b0;
      rst_core_q  <= 1'b0;
      rst_av_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      lock_s1     <= bus.pll_locked;
      lock_s      <= lock_s1;
      done_s1     <= bus.sdram_init_done;
      done_s      <= done_s1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      retries_q   <= retries_d;
      // Decode from the next state so the resets move on the same edge as the state.
      rst_sdram_q <= (state_d inside {SDRAM_WAIT, CORE_GAP, AV_GAP, RUN});
      rst_core_q  <= (state_d inside {CORE_GAP, AV_GAP, RUN});
      rst_av_q    <= (state_d inside {AV_GAP, RUN});
      ready_q     <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    retries_d = retries_q;
    if (bus.clear_sticky) sticky_d = 1'b0;
    if (state_q != WAIT_LOCK && !lock_s) begin
      // Lock loss outranks everything; setting the sticky flag beats a clear.
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      if (state_q == RUN) sticky_d = 1'b1;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end
        STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = SDRAM_WAIT;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        SDRAM_WAIT: begin
          if (done_s) begin
            state_d = CORE_GAP;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = STABLE;
            cnt_d   = '0;
            if (retries_q != 4'hF) retries_d = retries_q + 4'd1;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        CORE_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = AV_GAP;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        AV_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.rst_sdram_n      = rst_sdram_q;
  assign bus.rst_core_n       = rst_core_q;
  assign bus.rst_video_n      = rst_av_q;
  assign bus.rst_audio_n      = rst_av_q;
  assign bus.sys_ready        = ready_q;
  assign bus.lock_lost_sticky = sticky_q;
  assign bus.sdram_retries    = retries_q;
  assign bus.seq_state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a table of directed steps, hand-written corner sequences,
// and a randomized phase, all checked against a phase/duration model every cycle.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  reset_sequencer_if bus();

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .SDRAM_TIMEOUT     (16),
    .CNT_W             (16)
  ) dut (
    .clk_27m(clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- packing helpers ----------------
  // {sdram, core, video, audio, ready, sticky, retries[3:0], state[2:0]}
  function automatic logic [12:0] mk(input bit sd, input bit co, input bit av, input bit rdy,
                                     input bit stk, input int ret, input int st);
    return {sd, co, av, av, rdy, stk, 4'(ret), 3'(st)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.rst_sdram_n, bus.rst_core_n, bus.rst_video_n, bus.rst_audio_n,
            bus.sys_ready, bus.lock_lost_sticky, bus.sdram_retries, bus.seq_state};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase index with a table of phase lengths; outputs follow from the phase number.
  logic [12:0] exp_q[$];
  int m_ph = 0, m_t = 0, m_ret = 0;
  bit m_stk = 0, m_s1 = 0, m_s2 = 0, m_d1 = 0, m_d2 = 0;
  int dur[5] = '{0, 8, 16, 4, 4};

  task automatic model_edge();
    bit ls, ds;
    ls = m_s2;
    ds = m_d2;
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_d1 = 0; m_d2 = 0;
      m_ph = 0; m_t = 0; m_ret = 0; m_stk = 0;
    end else begin
      m_s2 = m_s1; m_s1 = bus.pll_locked;
      m_d2 = m_d1; m_d1 = bus.sdram_init_done;
      if (bus.clear_sticky) m_stk = 0;
      if (m_ph != 0 && !ls) begin
        if (m_ph == 5) m_stk = 1;
        m_ph = 0; m_t = 0;
      end else if (m_ph == 0) begin
        if (ls) begin m_ph = 1; m_t = 0; end
      end else if (m_ph == 2 && ds) begin
        m_ph = 3; m_t = 0;
      end else if (m_ph != 5) begin
        if (m_t == dur[m_ph] - 1) begin
          if (m_ph == 2) begin
            m_ph  = 1;
            m_ret = (m_ret < 15) ? m_ret + 1 : 15;
          end else m_ph++;
          m_t = 0;
        end else m_t++;
      end
    end
    exp_q.push_back(mk(m_ph >= 2, m_ph >= 3, m_ph >= 4, m_ph == 5, m_stk, m_ret, m_ph));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit r, input bit p, input bit d, input bit c);
    reset_n             = r;
    bus.pll_locked      = p;
    bus.sdram_init_done = d;
    bus.clear_sticky    = c;
  endtask

  task automatic tick();
    logic [12:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("model", dut_vec(), e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst_n, pll, done, clr;
    int          n;
    logic [12:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit r, input bit p, input bit d, input bit c, input int n,
                         input logic [12:0] e, input string name);
    vec_t v;
    v.rst_n = r; v.pll = p; v.done = d; v.clr = c; v.n = n; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    set_in(0, 0, 0, 0);

    add_vec(0, 0, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 0), "reset_state");
    add_vec(1, 1, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 0), "lock_sync_delay");
    add_vec(1, 1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1), "stable_edge3");
    add_vec(1, 1, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 1), "stable_edge10");
    add_vec(1, 1, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 2), "sdram_rel_edge11");
    add_vec(1, 1, 1, 0, 2, mk(1, 0, 0, 0, 0, 0, 2), "done_sync_delay");
    add_vec(1, 1, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 3), "core_release");
    add_vec(1, 1, 1, 0, 3, mk(1, 1, 0, 0, 0, 0, 3), "core_gap_hold");
    add_vec(1, 1, 1, 0, 1, mk(1, 1, 1, 0, 0, 0, 4), "av_release");
    add_vec(1, 1, 1, 0, 3, mk(1, 1, 1, 0, 0, 0, 4), "av_gap_hold");
    add_vec(1, 1, 1, 0, 1, mk(1, 1, 1, 1, 0, 0, 5), "run_entry");
    add_vec(1, 1, 0, 0, 5, mk(1, 1, 1, 1, 0, 0, 5), "run_ignores_done");
    add_vec(1, 0, 0, 0, 2, mk(1, 1, 1, 1, 0, 0, 5), "lock_loss_sync");
    add_vec(1, 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0), "lock_loss_drop");
    add_vec(1, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0), "sticky_clear");
    add_vec(1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0), "idle_after_clear");

    foreach (vecs[k]) begin
      set_in(vecs[k].rst_n, vecs[k].pll, vecs[k].done, vecs[k].clr);
      ticks(vecs[k].n);
      check(vecs[k].name, dut_vec(), vecs[k].exp);
    end

    // Short lock glitch during STABLE restarts the stable count.
    set_in(1, 1, 0, 0);
    ticks(3);
    check("glitch_stable", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));
    ticks(2);
    bus.pll_locked = 0;
    tick();
    bus.pll_locked = 1;
    ticks(2);
    check("glitch_to_wait", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    tick();
    check("glitch_restable", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));
    ticks(7);
    check("glitch_full_count", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));
    tick();
    check("glitch_sdram", dut_vec(), mk(1, 0, 0, 0, 0, 0, 2));

    // Lock loss from RUN with a clear on the same edge: set wins.
    bus.sdram_init_done = 1;
    ticks(11);
    check("run_again", dut_vec(), mk(1, 1, 1, 1, 0, 0, 5));
    bus.pll_locked = 0;
    ticks(2);
    bus.clear_sticky = 1;
    tick();
    bus.clear_sticky = 0;
    check("set_beats_clear", dut_vec(), mk(0, 0, 0, 0, 1, 0, 0));
    bus.clear_sticky = 1;
    tick();
    bus.clear_sticky = 0;
    check("clear_after_set", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));

    // SDRAM timeouts and retry saturation.
    set_in(0, 1, 0, 0);
    tick();
    check("reset_again", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    reset_n = 1;
    ticks(11);
    check("timeout_enter_wait", dut_vec(), mk(1, 0, 0, 0, 0, 0, 2));
    ticks(15);
    check("timeout_last_wait", dut_vec(), mk(1, 0, 0, 0, 0, 0, 2));
    tick();
    check("timeout_first", dut_vec(), mk(0, 0, 0, 0, 0, 1, 1));
    ticks(19 * 24);
    check("retries_saturate", dut_vec(), mk(0, 0, 0, 0, 0, 15, 1));

    // Reset during AV_GAP, then restart with lock held.
    set_in(0, 1, 1, 0);
    tick();
    reset_n = 1;
    ticks(12);
    check("pre_core", dut_vec(), mk(1, 1, 0, 0, 0, 0, 3));
    ticks(5);
    check("in_av_gap", dut_vec(), mk(1, 1, 1, 0, 0, 0, 4));
    reset_n = 0;
    tick();
    check("reset_mid_av", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    reset_n = 1;
    ticks(2);
    check("restart_sync", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));
    tick();
    check("restart_stable", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));

    // Randomized phase; the model check inside tick() compares every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if (bus.pll_locked) bus.pll_locked = ($urandom_range(0, 149) != 0);
      else                bus.pll_locked = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.sdram_init_done = ~bus.sdram_init_done;
      bus.clear_sticky = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
